cpu_run_monitor: RTL and testbench
==================================

// Module: cpu_run_monitor
// PURPOSE
//  Parametrised run controller/monitor for the LEGv8 CPU simulation environment. Gates CPU stepping
//  (cpu_en), counts cycles and stores, detects end-of-program (PC past imem, branch-to-self, timeout)
//  and optionally buffers register write-backs in a trace FIFO for the bench to drain and compare.
// PARAMETERS
//  PC_W        64    PC width
//  DATA_W      64    register write-data width
//  IMEM_WORDS  64    instruction words; end address = IMEM_WORDS*4 (byte PC)
//  SELF_LOOP_N 2     consecutive enabled cycles with unchanged PC that flag halt (>=1)
//  TIMEOUT     1000  max enabled cycles per run
//  CNT_W       32    counter width
//  TRACE_DEPTH 16    trace FIFO entries (power of 2, >=2)
// PORTS
//  clk          in   1         single clock, rising edge
//  rst_n        in   1         reset, asynchronous, active-low
//  run_req      in   1         1-cycle start pulse; accepted in IDLE or DONE
//  pc           in   PC_W      CPU instruction PC
//  reg_write    in   1         CPU RegWrite control
//  write_reg    in   5         CPU write register index
//  write_data   in   DATA_W    CPU write-back data
//  mem_write    in   1         CPU MemWrite control
//  cpu_en       out  1         CPU clock-enable (high only in RUN)
//  running      out  1         state == RUN
//  done         out  1         state == DONE
//  halt_cause   out  2         00 none, 01 pc_end, 10 self_loop, 11 timeout
//  cycle_cnt    out  CNT_W     enabled cycles this run
//  store_cnt    out  CNT_W     enabled cycles with mem_write
//  trace_pop    in   1         consume FIFO head (trace build only)
//  trace_valid  out  1         FIFO non-empty
//  trace_data   out  5+DATA_W  {reg, data} of head, show-ahead
//  trace_ovf    out  1         sticky: a push was dropped because FIFO full
// BEHAVIOUR
//  Reset: state IDLE; cpu_en, running, done, trace_valid, trace_ovf = 0; halt_cause = 00; counters 0.
//  FSM IDLE -run_req-> RUN; RUN -halt-> DONE; DONE -run_req-> RUN; run_req ignored in RUN.
//  RUN entry (same edge as run_req): cycle_cnt, store_cnt, self-loop counter, halt_cause cleared;
//   FIFO flushed, trace_ovf cleared. cpu_en combinational = (state == RUN).
//  Each RUN cycle: cycle_cnt+1; store_cnt+1 if mem_write; last_pc <= pc.
//   Self-loop counter: +1 if pc == last_pc (first RUN cycle never matches), else 0.
//  Halt evaluated in RUN, registered into DONE next edge; priority when simultaneous:
//   pc >= IMEM_WORDS*4 -> 01; self-loop counter reaches SELF_LOOP_N-1 with pc==last_pc -> 10;
//   cycle_cnt == TIMEOUT-1 -> 11. Counters include the halting cycle; hold in DONE.
//  Counters saturate at all-ones (no wrap).
//  Trace push: RUN & reg_write & write_reg != 31 (XZR). Full & push & !pop -> drop, trace_ovf=1.
//   Full & push & pop -> both occur. Empty & pop -> ignored. Pop legal in any state.
//  Async reset mid-run: immediate return to reset values, FIFO emptied.
// CONFIGURATION
//  RUN_MON_TRACE_EN defined: trace FIFO built as above.
//  Not defined: no FIFO storage; trace_valid=0, trace_data=0, trace_ovf=0, trace_pop ignored;
//   all other behaviour identical.
// STRUCTURE
//  Package run_mon_pkg: typedef state_e {IDLE,RUN,DONE}; typedef halt_cause_e (2-bit codes above);
//   localparam XZR_IDX=5'd31.
//  Sub-module trace_fifo (sync FIFO, DEPTH/WIDTH params, push/pop/full/empty, show-ahead),
//   instantiated only under RUN_MON_TRACE_EN.
// TESTING
//  1 Reset, run_req, pc stepping 0,4,..,256 (IMEM_WORDS=64) -> done when pc=256, cause 01, cycle_cnt=65.
//  2 pc held at 8 from cycle 3, SELF_LOOP_N=2 -> cause 10 one edge after second equal-PC cycle.
//  3 pc constant-changing, TIMEOUT=20 -> cause 11, cycle_cnt=20; pc_end on same cycle -> cause 01 wins.
//  4 reg_write on X1..X5 and X31, values 0xA..0xE -> 5 entries popped in order, X31 absent.
//  5 TRACE_DEPTH=4, 6 pushes without pop -> trace_ovf=1, 4 oldest retained; push+pop when full keeps count 4.
//  6 rst_n low mid-run -> cpu_en=0, counters 0 asynchronously; mem_write 3 cycles -> store_cnt=3.

Source files
------------

// File: rtl/run_mon_pkg.sv
// run_mon_pkg: shared types and constants for the CPU run monitor.
package run_mon_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    HC_NONE      = 2'd0,
    HC_PC_END    = 2'd1,
    HC_SELF_LOOP = 2'd2,
    HC_TIMEOUT   = 2'd3
  } halt_cause_e;

  // Architectural zero register; writes to it are never traced.
  localparam logic [4:0] XZR_IDX = 5'd31;

endpackage

// File: rtl/cpu_run_monitor_trace_fifo.sv
// trace_fifo: synchronous show-ahead FIFO with flush; DEPTH must be a power of 2 (>=2).
module trace_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 69
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  // A pop on an empty FIFO is ignored; a push into a full FIFO only lands if a pop frees the slot.
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_data    = r_mem[r_rd_ptr[AW-1:0]];

  // Pointer update; flush takes priority over any push/pop in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  // Storage write; contents need no reset since the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (w_do_push && !i_flush) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/cpu_run_monitor.sv
// cpu_run_monitor: gates CPU stepping, counts cycles/stores, detects end of program.
// Define RUN_MON_TRACE_EN to build the register write-back trace FIFO.
module cpu_run_monitor
  import run_mon_pkg::*;
#(
  parameter int unsigned PC_W        = 64,
  parameter int unsigned DATA_W      = 64,
  parameter int unsigned IMEM_WORDS  = 64,
  parameter int unsigned SELF_LOOP_N = 2,
  parameter int unsigned TIMEOUT     = 1000,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned TRACE_DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_run_req,
  input  logic [PC_W-1:0]   i_pc,
  input  logic              i_reg_write,
  input  logic [4:0]        i_write_reg,
  input  logic [DATA_W-1:0] i_write_data,
  input  logic              i_mem_write,
  output logic              o_cpu_en,
  output logic              o_running,
  output logic              o_done,
  output logic [1:0]        o_halt_cause,
  output logic [CNT_W-1:0]  o_cycle_cnt,
  output logic [CNT_W-1:0]  o_store_cnt,
  input  logic              i_trace_pop,
  output logic              o_trace_valid,
  output logic [DATA_W+4:0] o_trace_data,
  output logic              o_trace_ovf
);

  localparam logic [PC_W-1:0]  PC_END   = PC_W'(IMEM_WORDS * 4);
  localparam logic [CNT_W-1:0] SL_LAST  = CNT_W'(SELF_LOOP_N - 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_e            r_state;
  halt_cause_e       r_cause;
  logic [CNT_W-1:0]  r_cycle_cnt;
  logic [CNT_W-1:0]  r_store_cnt;
  logic [CNT_W-1:0]  r_sl_cnt;
  logic [PC_W-1:0]   r_last_pc;
  logic              r_first;

  logic              w_in_run;
  logic              w_start;
  logic              w_pc_match;
  halt_cause_e       w_cause;
  logic [CNT_W-1:0]  w_cycle_inc;
  logic [CNT_W-1:0]  w_store_inc;
  logic [CNT_W-1:0]  w_sl_inc;

  assign w_in_run    = (r_state == RUN);
  assign w_start     = i_run_req && !w_in_run;
  // The first RUN cycle has no valid previous PC to compare against.
  assign w_pc_match  = !r_first && (i_pc == r_last_pc);
  assign w_cycle_inc = (r_cycle_cnt == CNT_MAX) ? r_cycle_cnt : r_cycle_cnt + CNT_W'(1);
  assign w_store_inc = (r_store_cnt == CNT_MAX) ? r_store_cnt : r_store_cnt + CNT_W'(1);
  assign w_sl_inc    = (r_sl_cnt == CNT_MAX) ? r_sl_cnt : r_sl_cnt + CNT_W'(1);

  // Halt detection with fixed priority: pc_end, then self_loop, then timeout.
  always_comb begin
    w_cause = HC_NONE;
    if (i_pc >= PC_END)                       w_cause = HC_PC_END;
    else if (w_pc_match && r_sl_cnt == SL_LAST) w_cause = HC_SELF_LOOP;
    else if (r_cycle_cnt == TMO_LAST)         w_cause = HC_TIMEOUT;
  end

  // Run FSM with counters; counters clear on RUN entry and hold outside RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cause     <= HC_NONE;
      r_cycle_cnt <= '0;
      r_store_cnt <= '0;
      r_sl_cnt    <= '0;
      r_last_pc   <= '0;
      r_first     <= 1'b1;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (i_run_req) begin
            r_state     <= RUN;
            r_cause     <= HC_NONE;
            r_cycle_cnt <= '0;
            r_store_cnt <= '0;
            r_sl_cnt    <= '0;
            r_first     <= 1'b1;
          end
        end
        RUN: begin
          r_cycle_cnt <= w_cycle_inc;
          if (i_mem_write) r_store_cnt <= w_store_inc;
          r_last_pc <= i_pc;
          r_first   <= 1'b0;
          r_sl_cnt  <= w_pc_match ? w_sl_inc : '0;
          if (w_cause != HC_NONE) begin
            r_state <= DONE;
            r_cause <= w_cause;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_cpu_en     = w_in_run;
  assign o_running    = w_in_run;
  assign o_done       = (r_state == DONE);
  assign o_halt_cause = r_cause;
  assign o_cycle_cnt  = r_cycle_cnt;
  assign o_store_cnt  = r_store_cnt;

`ifdef RUN_MON_TRACE_EN
  logic w_push;
  logic w_full;
  logic w_empty;
  logic r_ovf;

  assign w_push = w_in_run && i_reg_write && (i_write_reg != XZR_IDX);

  trace_fifo #(
    .DEPTH (TRACE_DEPTH),
    .WIDTH (DATA_W + 5)
  ) u_trace_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (w_start),
    .i_push  (w_push),
    .i_data  ({i_write_reg, i_write_data}),
    .i_pop   (i_trace_pop),
    .o_data  (o_trace_data),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Sticky overflow: a push was lost because the FIFO was full with no pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                r_ovf <= 1'b0;
    else if (w_start)                          r_ovf <= 1'b0;
    else if (w_push && w_full && !i_trace_pop) r_ovf <= 1'b1;
  end

  assign o_trace_valid = !w_empty;
  assign o_trace_ovf   = r_ovf;
`else
  logic w_unused;

  assign w_unused      = ^{i_trace_pop, i_reg_write, i_write_reg, i_write_data,
                           w_start, (TRACE_DEPTH != 0)};
  assign o_trace_valid = 1'b0;
  assign o_trace_data  = '0;
  assign o_trace_ovf   = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_run_monitor.sv
// Bench for cpu_run_monitor: two instances (default and short-timeout/shallow-FIFO)
// share stimulus; scenario table for halt behaviour, scoreboard queues for the trace.
module tb_cpu_run_monitor;

`ifdef RUN_MON_TRACE_EN
  localparam bit TRACE_ON = 1'b1;
`else
  localparam bit TRACE_ON = 1'b0;
`endif
  localparam int unsigned DEPTH_M [2] = '{16, 4};

  typedef struct {
    int       pc0;
    int       step;
    int       hold;       // pc frozen from this cycle on (0 = never)
    int       force_end;  // cycle where pc is forced to 256 (0 = never)
    int       rr_mid;     // cycle with a run_req while running (0 = never)
    int       cyc_a;
    logic [1:0] cause_a;
    int       cyc_b;
    logic [1:0] cause_b;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run_req;
  logic [63:0] pc;
  logic        reg_write;
  logic [4:0]  write_reg;
  logic [63:0] write_data;
  logic        mem_write;
  logic        trace_pop;

  logic        cpu_en  [2];
  logic        running [2];
  logic        done_o  [2];
  logic [1:0]  cause   [2];
  logic [31:0] cyc     [2];
  logic [31:0] st      [2];
  logic        tv      [2];
  logic [68:0] td      [2];
  logic        tovf    [2];

  logic [68:0] q [2][$];
  bit          ovf_m [2];
  int          n_vec = 0;
  int          n_err = 0;
  vec_t        vecs [8];

  always #5 clk = ~clk;

  cpu_run_monitor u_dut_a (
    .clk(clk), .rst_n(rst_n), .i_run_req(run_req), .i_pc(pc),
    .i_reg_write(reg_write), .i_write_reg(write_reg), .i_write_data(write_data),
    .i_mem_write(mem_write), .o_cpu_en(cpu_en[0]), .o_running(running[0]),
    .o_done(done_o[0]), .o_halt_cause(cause[0]), .o_cycle_cnt(cyc[0]),
    .o_store_cnt(st[0]), .i_trace_pop(trace_pop), .o_trace_valid(tv[0]),
    .o_trace_data(td[0]), .o_trace_ovf(tovf[0])
  );

  cpu_run_monitor #(.SELF_LOOP_N(3), .TIMEOUT(20), .TRACE_DEPTH(4)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .i_run_req(run_req), .i_pc(pc),
    .i_reg_write(reg_write), .i_write_reg(write_reg), .i_write_data(write_data),
    .i_mem_write(mem_write), .o_cpu_en(cpu_en[1]), .o_running(running[1]),
    .o_done(done_o[1]), .o_halt_cause(cause[1]), .o_cycle_cnt(cyc[1]),
    .o_store_cnt(st[1]), .i_trace_pop(trace_pop), .o_trace_valid(tv[1]),
    .o_trace_data(td[1]), .o_trace_ovf(tovf[1])
  );

  task automatic chk(input string nm, input int d, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d: got %0h expected %0h (t=%0t)", nm, d, act, exp, $time);
    end
  endtask

  function automatic int exp_store(input int c);
    return (c < 2) ? 0 : (((c < 4) ? c : 4) - 1);
  endfunction

  // One clock: drive inputs, check trace head against the scoreboard, clock, update model.
  task automatic drive_cycle(input bit rr, input bit flush, input int unsigned p, input bit mw,
                             input bit rw, input logic [4:0] wr, input logic [63:0] wd, input bit pop);
    bit popd [2];
    int unsigned sz;
    run_req = rr; pc = 64'(p); mem_write = mw; reg_write = rw;
    write_reg = wr; write_data = wd; trace_pop = pop;
    for (int d = 0; d < 2; d++) begin
      chk("trace_valid", d, 128'(tv[d]), 128'(TRACE_ON && (q[d].size() > 0)));
      popd[d] = pop && TRACE_ON && (q[d].size() > 0);
      if (popd[d]) chk("trace_data", d, 128'(td[d]), 128'(q[d][0]));
`ifndef RUN_MON_TRACE_EN
      chk("trace_data_zero", d, 128'(td[d]), 128'(0));
`endif
    end
    @(posedge clk); #1;
    run_req = 1'b0;
    for (int d = 0; d < 2; d++) begin
      if (flush) begin
        q[d].delete();
        ovf_m[d] = 1'b0;
      end else begin
        sz = q[d].size();
        if (popd[d]) void'(q[d].pop_front());
        if (rw && wr != 5'd31) begin
          if (sz < DEPTH_M[d] || popd[d]) q[d].push_back({wr, wd});
          else ovf_m[d] = 1'b1;
        end
      end
      chk("trace_ovf", d, 128'(tovf[d]), 128'(TRACE_ON && ovf_m[d]));
    end
  endtask

  task automatic run_scenario(input int i);
    vec_t v;
    int dn [2];
    int ec [2];
    logic [1:0] ecause [2];
    int eff;
    int unsigned p;
    v = vecs[i];
    ec = '{v.cyc_a, v.cyc_b};
    ecause = '{v.cause_a, v.cause_b};
    dn = '{0, 0};
    drive_cycle(1'b1, 1'b1, 0, 1'b0, 1'b0, 5'd0, 64'd0, 1'b0);
    for (int k = 1; k <= 100 && (dn[0] == 0 || dn[1] == 0); k++) begin
      if (k == 1) begin
        for (int d = 0; d < 2; d++) begin
          chk("cpu_en_run", d, 128'(cpu_en[d]), 128'(1));
          chk("cause_clr", d, 128'(cause[d]), 128'(0));
        end
      end
      eff = (v.hold != 0 && k > v.hold) ? v.hold : k;
      p = 32'(v.pc0 + v.step * (eff - 1));
      if (k == v.force_end) p = 256;
      drive_cycle(k == v.rr_mid, 1'b0, p, (k >= 2 && k <= 4), 1'b0, 5'd0, 64'd0, 1'b0);
      for (int d = 0; d < 2; d++)
        if (dn[d] == 0 && done_o[d]) dn[d] = k;
    end
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("halt_cycle_s%0d", i), d, 128'(dn[d]), 128'(ec[d]));
      chk($sformatf("halt_cause_s%0d", i), d, 128'(cause[d]), 128'(ecause[d]));
      chk($sformatf("cycle_cnt_s%0d", i), d, 128'(cyc[d]), 128'(ec[d]));
      chk($sformatf("store_cnt_s%0d", i), d, 128'(st[d]), 128'(exp_store(ec[d])));
      chk($sformatf("cpu_en_done_s%0d", i), d, 128'(cpu_en[d]), 128'(0));
    end
  endtask

  // Write-back trace: X31 skipped, shallow FIFO overflows, push+pop while full.
  task automatic trace_seq();
    logic [4:0] wrl [8];
    int dn [2];
    wrl = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd31, 5'd5, 5'd6, 5'd7};
    dn = '{0, 0};
    drive_cycle(1'b1, 1'b1, 0, 1'b0, 1'b0, 5'd0, 64'd0, 1'b0);
    for (int k = 1; k <= 100 && (dn[0] == 0 || dn[1] == 0); k++) begin
      if (k <= 8)
        drive_cycle(1'b0, 1'b0, 32'(4 * (k - 1)), 1'b0, 1'b1, wrl[k-1], 64'('hA + k - 1), k == 8);
      else
        drive_cycle(1'b0, 1'b0, 32'(4 * (k - 1)), 1'b0, 1'b0, 5'd0, 64'd0, k <= 18);
      for (int d = 0; d < 2; d++)
        if (dn[d] == 0 && done_o[d]) dn[d] = k;
    end
    chk("trace_halt_cycle", 0, 128'(dn[0]), 128'(65));
    chk("trace_halt_cycle", 1, 128'(dn[1]), 128'(20));
    chk("trace_halt_cause", 0, 128'(cause[0]), 128'(1));
    chk("trace_halt_cause", 1, 128'(cause[1]), 128'(3));
  endtask

  initial begin : watchdog
    #200us;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{0,   4, 0,  0,  10, 65, 2'b01, 20, 2'b11};
    vecs[1] = '{0,   4, 0,  20, 0,  20, 2'b01, 20, 2'b01};
    vecs[2] = '{0,   4, 3,  0,  0,  5,  2'b10, 6,  2'b10};
    vecs[3] = '{8,   0, 0,  0,  0,  3,  2'b10, 4,  2'b10};
    vecs[4] = '{0,   4, 17, 0,  0,  19, 2'b10, 20, 2'b10};
    vecs[5] = '{248, 4, 0,  0,  0,  3,  2'b01, 3,  2'b01};
    vecs[6] = '{256, 0, 0,  0,  0,  1,  2'b01, 1,  2'b01};
    vecs[7] = '{252, 0, 0,  0,  0,  3,  2'b10, 4,  2'b10};

    rst_n = 1'b1; run_req = 1'b0; pc = '0; reg_write = 1'b0; write_reg = '0;
    write_data = '0; mem_write = 1'b0; trace_pop = 1'b0;
    ovf_m = '{1'b0, 1'b0};
    #1 rst_n = 1'b0;
    #2;
    for (int d = 0; d < 2; d++) begin
      chk("rst_cpu_en", d, 128'(cpu_en[d]), 128'(0));
      chk("rst_running", d, 128'(running[d]), 128'(0));
      chk("rst_done", d, 128'(done_o[d]), 128'(0));
      chk("rst_cause", d, 128'(cause[d]), 128'(0));
      chk("rst_cycle_cnt", d, 128'(cyc[d]), 128'(0));
      chk("rst_store_cnt", d, 128'(st[d]), 128'(0));
      chk("rst_trace_valid", d, 128'(tv[d]), 128'(0));
      chk("rst_trace_ovf", d, 128'(tovf[d]), 128'(0));
    end
    #9 rst_n = 1'b1;
    @(posedge clk); #1;

    trace_seq();
    for (int i = 0; i < 8; i++) run_scenario(i);

    // Asynchronous reset in the middle of a run.
    drive_cycle(1'b1, 1'b1, 0, 1'b0, 1'b0, 5'd0, 64'd0, 1'b0);
    for (int k = 1; k <= 5; k++)
      drive_cycle(1'b0, 1'b0, 32'(4 * (k - 1)), (k >= 2 && k <= 4), k == 1, 5'd1, 64'h55, 1'b0);
    for (int d = 0; d < 2; d++) begin
      chk("mid_cycle_cnt", d, 128'(cyc[d]), 128'(5));
      chk("mid_store_cnt", d, 128'(st[d]), 128'(3));
      chk("mid_running", d, 128'(running[d]), 128'(1));
    end
    #2 rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("arst_cpu_en", d, 128'(cpu_en[d]), 128'(0));
      chk("arst_cycle_cnt", d, 128'(cyc[d]), 128'(0));
      chk("arst_store_cnt", d, 128'(st[d]), 128'(0));
      chk("arst_trace_valid", d, 128'(tv[d]), 128'(0));
      chk("arst_done", d, 128'(done_o[d]), 128'(0));
      q[d].delete();
      ovf_m[d] = 1'b0;
    end
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    for (int d = 0; d < 2; d++)
      chk("post_rst_idle", d, 128'(running[d]), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
